ecap5_dwbgpio: RTL and testbench
================================

// Module: ecap5_dwbgpio
//
// PURPOSE
//  Wishbone pipelined slave (responder) GPIO peripheral driving board LEDs and sampling buttons.
//  Sits behind the SoC interconnect alongside BRAM/UART; the interconnect decodes the region and gates wb_cyc_i.
//  Provides an output register, debounced input status and sticky rising-edge flags.
//
// PARAMETERS
//  NB_OUT           2       number of output pins (<=32)
//  NB_IN            2       number of input pins (<=32)
//  DEBOUNCE_CYCLES  250000  cycles an input must hold a new level before it is accepted (>=2)
//
// PORTS
//  clk_i       in   1       system clock; everything is on its rising edge
//  rst_i       in   1       synchronous, active-low reset
//  wb_adr_i    in   32      byte address; only [3:2] decoded
//  wb_dat_i    in   32      write data
//  wb_dat_o    out  32      read data, valid while wb_ack_o=1
//  wb_sel_i    in   4       byte enables for writes
//  wb_we_i     in   1       1=write, 0=read
//  wb_stb_i    in   1       request strobe
//  wb_ack_o    out  1       transfer acknowledge
//  wb_cyc_i    in   1       bus cycle active
//  wb_stall_o  out  1       always 0 (never stalls)
//  gpio_o      out  NB_OUT  output pins (LEDs)
//  gpio_i      in   NB_IN   asynchronous input pins (buttons)
//
// BEHAVIOUR
//  Reset (rst_i=0 at a clock edge): wb_ack_o=0, wb_dat_o=0, gpio_o=0, OUT=0, EDGE=0.
//  Reset also clears the synchronisers, the stable levels and the debounce counters to 0.
//  Register map (word offset = adr[3:2]):
//   0x0 OUT   RW  [NB_OUT-1:0] drives gpio_o; upper bits read 0.
//   0x4 IN    RO  [NB_IN-1:0] debounced levels; writes ignored.
//   0x8 EDGE  W1C [NB_IN-1:0] sticky flag, set on a debounced 0->1 transition.
//   0xC ID    RO  constant 32'h4750_494F ("GPIO").
//  Handshake:
//   - A request is accepted when wb_cyc_i & wb_stb_i; wb_stall_o=0, so back-to-back requests are accepted every cycle.
//   - wb_ack_o=1 exactly 1 cycle after acceptance, one ack per request.
//   - wb_dat_o is registered from the register value at acceptance; it is 0 for writes and whenever ack=0.
//   - If wb_cyc_i=0 in the ack cycle, the ack is still driven and the master ignores it.
//   - Write side effects are visible the cycle after acceptance (gpio_o updates with ack).
//  Byte enables: OUT and EDGE writes touch only the bytes with wb_sel_i[b]=1; wb_sel_i=0 writes nothing.
//  EDGE set/clear collision: if a set event and a W1C clear of the same bit fall in the same cycle, set wins.
//  Input path, per bit:
//   - 2-FF synchroniser, then a debounce counter of width $clog2(DEBOUNCE_CYCLES).
//   - sync==stable -> counter=0.
//   - sync!=stable -> counter++; when counter==DEBOUNCE_CYCLES-1, stable<=sync and counter<=0.
//   - A glitch shorter than DEBOUNCE_CYCLES resets the count and produces no change.
//   - Latency from a gpio_i edge to IN/EDGE updating: 2+DEBOUNCE_CYCLES cycles.
//  Reset mid-transfer: the pending ack is dropped. Reset mid-debounce: the count restarts from 0.
//
// STRUCTURE
//  Package ecap5_dwbgpio_pkg: register offset localparams (GPIO_OUT=2'd0, GPIO_IN=2'd1, GPIO_EDGE=2'd2, GPIO_ID=2'd3)
//   and the ID constant.
//  Sub-module ecap5_dwbgpio_debounce, instantiated NB_IN times via generate.
//   Params: CYCLES. Ports: clk_i, rst_i, in_i, level_o, rise_o (1-cycle pulse on a 0->1 accept).
//  Top level: Wishbone decode, ack/data pipeline register, OUT/EDGE registers.
//
// TESTING (use DEBOUNCE_CYCLES=4 in the bench)
//  1. Reset: hold rst_i=0 for 3 cycles with gpio_i=2'b11 -> gpio_o=0, wb_ack_o=0; IN reads 0 at the first read after release.
//  2. Write OUT=32'h3, sel=4'hF -> ack 1 cycle later, gpio_o=2'b11 in the ack cycle; readback gives 32'h3.
//     Write with sel=4'h0 -> gpio_o unchanged.
//  3. Back-to-back reads of ID, OUT, IN on consecutive cycles, stall=0 -> three consecutive acks
//     with dat 32'h4750494F, 32'h3, 32'h0.
//  4. Pulse gpio_i[0] high for 3 cycles -> IN stays 0, EDGE stays 0.
//     Hold it high for 10 cycles -> IN=32'h1 exactly 6 cycles after the edge, and EDGE=32'h1.
//  5. Write EDGE=32'h1 -> reads 0. Repeat the write in the same cycle that a debounced rise of bit 0 occurs
//     -> EDGE reads 32'h1 (set wins).
//  6. Read IN, then assert rst_i=0 in the acceptance cycle -> no ack follows; OUT reads 0 afterwards.

Source files
------------

// File: rtl/ecap5_dwbgpio_pkg.sv
// rtl/ecap5_dwbgpio_pkg.sv - register map constants and helpers for the GPIO peripheral
package ecap5_dwbgpio_pkg;

  localparam logic [1:0] GPIO_OUT  = 2'd0;
  localparam logic [1:0] GPIO_IN   = 2'd1;
  localparam logic [1:0] GPIO_EDGE = 2'd2;
  localparam logic [1:0] GPIO_ID   = 2'd3;

  localparam logic [31:0] GPIO_ID_VALUE = 32'h4750_494F;

  // Expands the 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ecap5_dwbgpio_if.sv
// rtl/ecap5_dwbgpio_if.sv - Wishbone pipelined bus bundle, named from the responder's side
interface ecap5_dwbgpio_if;

  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_cyc_i;
  logic        wb_stall_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

endinterface

// File: rtl/ecap5_dwbgpio_debounce.sv
// rtl/ecap5_dwbgpio_debounce.sv - 2-FF synchroniser plus hold-time debounce for one input pin
module ecap5_dwbgpio_debounce #(
  parameter int CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    sync1_d  = in_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = (sync2_q != stable_q) && (cnt_q == CNT_MAX);
    // Any return to the stable level drops the count, so glitches never accumulate.
    if (sync2_q != stable_q) begin
      if (accept) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Asserted in the cycle whose closing edge flips the level, so EDGE lands together with IN.
  assign rise_o  = accept & sync2_q;
  assign level_o = stable_q;

endmodule

// File: rtl/ecap5_dwbgpio.sv
// rtl/ecap5_dwbgpio.sv - Wishbone pipelined GPIO responder: OUT, debounced IN, W1C EDGE, ID
module ecap5_dwbgpio
  import ecap5_dwbgpio_pkg::*;
#(
  parameter int NB_OUT          = 2,
  parameter int NB_IN           = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ecap5_dwbgpio_if.slave    wb,
  output logic [NB_OUT-1:0] gpio_o,
  input  logic [NB_IN-1:0]  gpio_i
);

  logic [NB_IN-1:0]  in_level;
  logic [NB_IN-1:0]  in_rise;

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [NB_OUT-1:0] out_q, out_d;
  logic [NB_IN-1:0]  edge_q, edge_d;

  logic              accept;
  logic              is_write;
  logic [1:0]        idx;
  logic [31:0]       wmask;
  logic [31:0]       rdata;
  logic              unused_adr;

  for (genvar i = 0; i < NB_IN; i++) begin : g_in
    ecap5_dwbgpio_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .in_i    (gpio_i[i]),
      .level_o (in_level[i]),
      .rise_o  (in_rise[i])
    );
  end

  always_comb begin
    accept   = wb.wb_cyc_i & wb.wb_stb_i;
    is_write = accept & wb.wb_we_i;
    idx      = wb.wb_adr_i[3:2];
    wmask    = byte_mask(wb.wb_sel_i);

    rdata = '0;
    case (idx)
      GPIO_OUT:  rdata[NB_OUT-1:0] = out_q;
      GPIO_IN:   rdata[NB_IN-1:0]  = in_level;
      GPIO_EDGE: rdata[NB_IN-1:0]  = edge_q;
      default:   rdata             = GPIO_ID_VALUE;
    endcase

    ack_d = accept;
    dat_d = (accept && !wb.wb_we_i) ? rdata : '0;

    out_d = out_q;
    if (is_write && idx == GPIO_OUT) begin
      for (int i = 0; i < NB_OUT; i++) begin
        if (wmask[i]) out_d[i] = wb.wb_dat_i[i];
      end
    end

    edge_d = edge_q;
    if (is_write && idx == GPIO_EDGE) begin
      for (int i = 0; i < NB_IN; i++) begin
        if (wmask[i] && wb.wb_dat_i[i]) edge_d[i] = 1'b0;
      end
    end
    // Applied after the clear so a simultaneous rise is never lost.
    edge_d = edge_d | in_rise;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      out_q  <= '0;
      edge_q <= '0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      out_q  <= out_d;
      edge_q <= edge_d;
    end
  end

  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = 1'b0;
  assign gpio_o        = out_q;

  assign unused_adr = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0]};

endmodule

// File: tb/tb_ecap5_dwbgpio.sv
// tb/tb_ecap5_dwbgpio.sv - directed self-checking bench for ecap5_dwbgpio
module tb_ecap5_dwbgpio;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] gpio_i = 2'b00;
  logic [1:0] gpio_o;

  int n_checks = 0;
  int n_fail   = 0;

  ecap5_dwbgpio_if wb ();

  ecap5_dwbgpio #(
    .NB_OUT          (2),
    .NB_IN           (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .wb     (wb),
    .gpio_o (gpio_o),
    .gpio_i (gpio_i)
  );

  always #5 clk = ~clk;

  task automatic idle_bus();
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 32'h0;
    wb.wb_dat_i = 32'h0;
    wb.wb_sel_i = 4'h0;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    wb.wb_sel_i = sel;
  endtask

  // One request; returns what the responder shows in the cycle after acceptance.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic ack, output logic [31:0] rdat);
    @(posedge clk); #1;
    drive(we, adr, dat, sel);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    ack  = wb.wb_ack_o;
    rdat = wb.wb_dat_o;
  endtask

  task automatic test_reset();
    logic        ack;
    logic [31:0] rd;
    idle_bus();
    rst_i  = 1'b0;
    gpio_i = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (gpio_o !== 2'b00) begin n_fail++; $display("FAIL reset_gpio_o: got %b want 00", gpio_o); end
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", wb.wb_dat_o); end
    @(posedge clk); #1;
    rst_i = 1'b1;
    xfer(1'b0, 32'h4, 32'h0, 4'h0, ack, rd);
    gpio_i = 2'b00;
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL reset_first_in_ack: got %b want 1", ack); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_first_in: got %h want 0", rd); end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_write_out();
    logic        ack;
    logic [31:0] rd;
    xfer(1'b1, 32'h0, 32'h3, 4'hF, ack, rd);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL out_wr_ack: got %b want 1", ack); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL out_wr_dat: got %h want 0", rd); end
    n_checks++; if (gpio_o !== 2'b11) begin n_fail++; $display("FAIL out_wr_gpio: got %b want 11", gpio_o); end
    xfer(1'b0, 32'h0, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL out_readback: got %h want 3", rd); end
    xfer(1'b1, 32'h0, 32'h0, 4'h0, ack, rd);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL out_sel0_ack: got %b want 1", ack); end
    n_checks++; if (gpio_o !== 2'b11) begin n_fail++; $display("FAIL out_sel0_gpio: got %b want 11", gpio_o); end
    xfer(1'b1, 32'h0, 32'h0, 4'hE, ack, rd);
    n_checks++; if (gpio_o !== 2'b11) begin n_fail++; $display("FAIL out_selE_gpio: got %b want 11", gpio_o); end
    xfer(1'b1, 32'h0, 32'hFFFF_FFFD, 4'hF, ack, rd);
    n_checks++; if (gpio_o !== 2'b01) begin n_fail++; $display("FAIL out_wide_gpio: got %b want 01", gpio_o); end
    xfer(1'b0, 32'h0, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL out_upper_zero: got %h want 1", rd); end
    xfer(1'b1, 32'h0, 32'h3, 4'h1, ack, rd);
    n_checks++; if (gpio_o !== 2'b11) begin n_fail++; $display("FAIL out_sel1_gpio: got %b want 11", gpio_o); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive(1'b0, 32'hC, 32'h0, 4'h0);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++; if (wb.wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", wb.wb_stall_o); end
    n_checks++; if (wb.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack0: got %b want 1", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 32'h4750494F) begin n_fail++; $display("FAIL b2b_id: got %h want 4750494f", wb.wb_dat_o); end
    @(posedge clk); #1;
    drive(1'b0, 32'h4, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++; if (wb.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack1: got %b want 1", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 32'h3) begin n_fail++; $display("FAIL b2b_out: got %h want 3", wb.wb_dat_o); end
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    n_checks++; if (wb.wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2: got %b want 1", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL b2b_in: got %h want 0", wb.wb_dat_o); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra_ack: got %b want 0", wb.wb_ack_o); end
    n_checks++; if (wb.wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL b2b_dat_idle: got %h want 0", wb.wb_dat_o); end
  endtask

  task automatic test_debounce();
    logic        ack;
    logic [31:0] rd;
    logic [31:0] exp;
    @(posedge clk); #1;
    gpio_i = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    gpio_i = 2'b00;
    repeat (10) @(posedge clk);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL glitch_in: got %h want 0", rd); end
    xfer(1'b0, 32'h8, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL glitch_edge: got %h want 0", rd); end

    // Continuous IN reads: the read accepted at edge k shows the level after edge k-1.
    @(posedge clk); #1;
    gpio_i = 2'b01;
    drive(1'b0, 32'h4, 32'h0, 4'h0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (k >= 7) ? 32'h1 : 32'h0;
      n_checks++;
      if (wb.wb_dat_o !== exp) begin
        n_fail++; $display("FAIL debounce_latency k=%0d: got %h want %h", k, wb.wb_dat_o, exp);
      end
    end
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    gpio_i = 2'b00;
    xfer(1'b0, 32'h8, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL rise_edge: got %h want 1", rd); end
    repeat (12) @(posedge clk);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL fall_in: got %h want 0", rd); end
    xfer(1'b0, 32'h8, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL fall_edge_sticky: got %h want 1", rd); end
  endtask

  task automatic test_edge_w1c();
    logic        ack;
    logic [31:0] rd;
    xfer(1'b1, 32'h8, 32'h1, 4'hF, ack, rd);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL w1c_ack: got %b want 1", ack); end
    xfer(1'b0, 32'h8, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h want 0", rd); end

    // Clear lands on the same edge as the debounced rise (edge 6 after the pin edge).
    @(posedge clk); #1;
    gpio_i = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    drive(1'b1, 32'h8, 32'h1, 4'hF);
    @(posedge clk); #1;
    idle_bus();
    xfer(1'b0, 32'h8, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL set_wins: got %h want 1", rd); end
    xfer(1'b0, 32'h4, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL collision_in: got %h want 1", rd); end
    xfer(1'b1, 32'h8, 32'h1, 4'h0, ack, rd);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL w1c_sel0: got %h want 1", rd); end
    xfer(1'b1, 32'h8, 32'h1, 4'h1, ack, rd);
    xfer(1'b0, 32'h8, 32'h0, 4'h0, ack, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_sel1: got %h want 0", rd); end
    gpio_i = 2'b00;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic        ack;
    logic [31:0] rd;
    @(posedge clk); #1;
    drive(1'b0, 32'h4, 32'h0, 4'h0);
    rst_i = 1'b0;
    @(posedge clk); #1;
    idle_bus();
    rst_i = 1'b1;
    @(negedge clk);
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 0", wb.wb_ack_o); end
    n_checks++; if (gpio_o !== 2'b00) begin n_fail++; $display("FAIL rst_mid_gpio: got %b want 00", gpio_o); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (wb.wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack_late: got %b want 0", wb.wb_ack_o); end
    xfer(1'b0, 32'h0, 32'h0, 4'h0, ack, rd);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_mid_out_ack: got %b want 1", ack); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_out: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_write_out();
    test_back_to_back();
    test_debounce();
    test_edge_w1c();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
